imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the decode stage.
//  - Accepts 32-bit RISC-V instructions on a valid/ready stream.
//  - Classifies the immediate format and emits the sign-extended XLEN-wide immediate,

---
 rtl/imm_gen_pipe.sv | 168 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes format/immediate, carries a tag through
// STAGES elastic register stages. Define IMMGEN_RVC_EN to decode 16-bit compressed forms.
module imm_gen_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_rvc,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5
    } fmt_e;

    localparam int unsigned Last = STAGES - 1;

    fmt_e            dec_fmt;
    logic [31:0]     dec_imm32;
    logic            dec_rvc;
    logic [XLEN-1:0] dec_imm;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] rdy;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [2:0]        fmt_q [STAGES];
    logic              rvc_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

    always_comb begin
        dec_fmt   = FmtNone;
        dec_imm32 = '0;
        dec_rvc   = 1'b0;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                    dec_fmt   = FmtI;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                7'b0100011: begin
                    dec_fmt   = FmtS;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                7'b1100011: begin
                    dec_fmt   = FmtB;
                    dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                 in_instr[30:25], in_instr[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec_fmt   = FmtU;
                    dec_imm32 = {in_instr[31:12], 12'b0};
                end
                7'b1101111: begin
                    dec_fmt   = FmtJ;
                    dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
                end
                default: ;
            endcase
        end
`ifdef IMMGEN_RVC_EN
        else begin
            dec_rvc = 1'b1;
            // Keyed on {quadrant, funct3}.
            case ({in_instr[1:0], in_instr[15:13]})
                5'b01_000, 5'b01_010: begin
                    dec_fmt   = FmtI;
                    dec_imm32 = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
                end
                5'b00_010: begin
                    dec_fmt   = FmtI;
                    dec_imm32 = {25'b0, in_instr[5], in_instr[12:10], in_instr[6], 2'b00};
                end
                5'b00_110: begin
                    dec_fmt   = FmtS;
                    dec_imm32 = {25'b0, in_instr[5], in_instr[12:10], in_instr[6], 2'b00};
                end
                5'b01_101: begin
                    dec_fmt   = FmtJ;
                    dec_imm32 = {{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9],
                                 in_instr[6], in_instr[7], in_instr[2], in_instr[11],
                                 in_instr[5:3], 1'b0};
                end
                5'b01_110, 5'b01_111: begin
                    dec_fmt   = FmtB;
                    dec_imm32 = {{23{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2],
                                 in_instr[11:10], in_instr[4:3], 1'b0};
                end
                default: ;
            endcase
        end
`endif
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

    // Closed form of ready_k = !valid_k || ready_{k+1}: a stage is blocked only when it and
    // every stage after it are full and the consumer stalls.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        rdy       = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            full_tail = full_tail & valid_q[k];
            rdy[k]    = out_ready | ~full_tail;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                imm_q[k] <= '0;
                fmt_q[k] <= '0;
                rvc_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    imm_q[0] <= dec_imm;
                    fmt_q[0] <= dec_fmt;
                    rvc_q[0] <= dec_rvc;
                    tag_q[0] <= in_tag;
                end
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        imm_q[k] <= imm_q[k-1];
                        fmt_q[k] <= fmt_q[k-1];
                        rvc_q[k] <= rvc_q[k-1];
                        tag_q[k] <= tag_q[k-1];
                    end
                end
            end
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[Last];
    assign out_imm   = imm_q[Last];
    assign out_fmt   = fmt_q[Last];
    assign out_rvc   = rvc_q[Last];
    assign out_tag   = tag_q[Last];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_imm_gen_pipe;
    localparam int unsigned STAGES = 2;
    localparam int NTBL = 10;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        rvc;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready32, in_ready64, out_valid32, out_valid64, out_rvc32, out_rvc64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt32, out_fmt64;
    logic [3:0]  out_tag32, out_tag64;

    exp_t sb[$];
    exp_t cur_exp;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    logic [31:0] tbl_instr [NTBL];
    logic [63:0] tbl_imm   [NTBL];
    logic [2:0]  tbl_fmt   [NTBL];
    logic        tbl_rvc   [NTBL];

    imm_gen_pipe #(.XLEN(32), .STAGES(STAGES), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_rvc(out_rvc32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(STAGES), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_rvc(out_rvc64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    // Accepted inputs enter the scoreboard; flush or reset kills whatever is in flight.
    always @(negedge clk) begin
        if (!rst && !flush && in_valid && in_ready32) begin
            cur_exp.cyc = cyc;
            sb.push_back(cur_exp);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || flush) sb.delete();
    end

    task automatic fill_table();
        tbl_instr[0] = 32'hFFF00093; tbl_imm[0] = 64'hFFFFFFFF_FFFFFFFF; tbl_fmt[0] = 3'd1;
        tbl_instr[1] = 32'hFE000EE3; tbl_imm[1] = 64'hFFFFFFFF_FFFFFFFC; tbl_fmt[1] = 3'd3;
        tbl_instr[2] = 32'h12345037; tbl_imm[2] = 64'h00000000_12345000; tbl_fmt[2] = 3'd4;
        tbl_instr[3] = 32'h00000000; tbl_imm[3] = 64'h0;                 tbl_fmt[3] = 3'd0;
        tbl_instr[4] = 32'hFF9FF06F; tbl_imm[4] = 64'hFFFFFFFF_FFFFFFF8; tbl_fmt[4] = 3'd5;
        tbl_instr[6] = 32'h00512423; tbl_imm[6] = 64'h8;                 tbl_fmt[6] = 3'd2;
        tbl_instr[7] = 32'h80000017; tbl_imm[7] = 64'hFFFFFFFF_80000000; tbl_fmt[7] = 3'd4;
        tbl_instr[8] = 32'h0000000B; tbl_imm[8] = 64'h0;                 tbl_fmt[8] = 3'd0;
        tbl_instr[5] = 32'h0000557D;
        tbl_instr[9] = 32'h000040C0;
        for (int i = 0; i < NTBL; i++) tbl_rvc[i] = 1'b0;
`ifdef IMMGEN_RVC_EN
        tbl_imm[5] = 64'hFFFFFFFF_FFFFFFFF; tbl_fmt[5] = 3'd1; tbl_rvc[5] = 1'b1;
        tbl_imm[9] = 64'h4;                 tbl_fmt[9] = 3'd1; tbl_rvc[9] = 1'b1;
        tbl_rvc[3] = 1'b1;
`else
        tbl_imm[5] = 64'h0; tbl_fmt[5] = 3'd0;
        tbl_imm[9] = 64'h0; tbl_fmt[9] = 3'd0;
`endif
    endtask

    task automatic drive(input int idx, input logic [3:0] tag);
        in_instr    = tbl_instr[idx];
        in_tag      = tag;
        in_valid    = 1'b1;
        cur_exp.imm = tbl_imm[idx];
        cur_exp.fmt = tbl_fmt[idx];
        cur_exp.rvc = tbl_rvc[idx];
        cur_exp.tag = tag;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid32, out_valid64, out_imm32, out_imm64, out_fmt32, out_fmt64,
             out_rvc32, out_rvc64, out_tag32, out_tag64} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b/%b imm=%h/%h fmt=%0d tag=%0d, required all 0",
                     out_valid32, out_valid64, out_imm32, out_imm64, out_fmt32, out_tag32);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b/%b out_valid=%b, required 1/1 0",
                     in_ready32, in_ready64, out_valid32);
        end
        @(posedge clk);
        #1;
    endtask

    // Back-to-back stream of every table entry with the consumer always ready.
    task automatic test_formats();
        int   idx, got;
        logic acc;
        exp_t e;
        out_ready = 1'b1;
        idx = 0;
        got = 0;
        drive(0, 4'd0);
        for (int b = 0; b < 60 && got < NTBL; b++) begin
            @(negedge clk);
            if (out_valid32 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL formats_spurious: out tag=%0d, required no output", out_tag32);
                end else begin
                    e = sb.pop_front();
                    if ({out_imm64, out_imm32, out_fmt64, out_fmt32, out_rvc64, out_rvc32,
                         out_tag64, out_tag32} !== {e.imm, e.imm[31:0], e.fmt, e.fmt, e.rvc,
                         e.rvc, e.tag, e.tag}) begin
                        errors++;
                        $display("FAIL formats_entry: imm=%h/%h fmt=%0d/%0d rvc=%b/%b tag=%0d/%0d, required imm=%h fmt=%0d rvc=%b tag=%0d",
                                 out_imm64, out_imm32, out_fmt64, out_fmt32, out_rvc64, out_rvc32,
                                 out_tag64, out_tag32, e.imm, e.fmt, e.rvc, e.tag);
                    end
                    checks++;
                    if (cyc - e.cyc != int'(STAGES)) begin
                        errors++;
                        $display("FAIL formats_latency: tag=%0d latency=%0d, required %0d",
                                 e.tag, cyc - e.cyc, STAGES);
                    end
                end
                got++;
            end
            acc = in_valid && in_ready32;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < NTBL) drive(idx, 4'(idx));
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (got != NTBL) begin
            errors++;
            $display("FAIL formats_count: got %0d outputs, required %0d", got, NTBL);
        end
    endtask

    task automatic test_backpressure();
        int   accepts, got, next_tag;
        logic acc, rdy_seen;
        exp_t e;
        out_ready = 1'b0;
        accepts = 0;
        next_tag = 1;
        drive(2, 4'd1);
        rdy_seen = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rdy_seen = in_ready32 | in_ready64;
            acc = in_valid && in_ready32;
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                next_tag++;
                drive(next_tag == 2 ? 4 : 6, 4'(next_tag));
            end
        end
        checks++;
        if (accepts != 2 || rdy_seen !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepts=%0d in_ready=%b, required 2 and 0", accepts, rdy_seen);
        end
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b1 || out_tag32 !== 4'd1 || out_imm32 !== 32'h12345000) begin
            errors++;
            $display("FAIL bp_hold: valid=%b tag=%0d imm=%h, required 1 1 12345000",
                     out_valid32, out_tag32, out_imm32);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b/%b, required 1", in_ready32, in_ready64);
        end
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            if (out_valid32 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL bp_spurious: out tag=%0d, required no output", out_tag32);
                end else begin
                    e = sb.pop_front();
                    if ({out_imm64, out_fmt32, out_tag64, out_tag32} !==
                        {e.imm, e.fmt, e.tag, e.tag} || out_tag32 !== 4'(got + 1)) begin
                        errors++;
                        $display("FAIL bp_order: tag=%0d imm=%h fmt=%0d, required tag=%0d imm=%h fmt=%0d",
                                 out_tag32, out_imm64, out_fmt32, got + 1, e.imm, e.fmt);
                    end
                end
                got++;
            end
            acc = in_valid && in_ready32;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs, required 3", got);
        end
    endtask

    task automatic test_flush();
        int   accepts;
        logic acc;
        exp_t e;
        out_ready = 1'b0;
        accepts = 0;
        drive(0, 4'd4);
        for (int c = 0; c < 6 && accepts < 2; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready32;
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                drive(7, 4'd5);
            end
        end
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1, 4'd6);
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL flush_cycle: in_ready=%b out_valid=%b queued=%0d, required 1 1 >0",
                     in_ready32, out_valid32, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (out_tag32 !== e.tag || out_imm64 !== e.imm) begin
                errors++;
                $display("FAIL flush_head: tag=%0d imm=%h, required tag=%0d imm=%h",
                         out_tag32, out_imm64, e.tag, e.imm);
            end
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
                errors++;
                $display("FAIL flush_killed: out_valid=%b/%b tag=%0d at cycle %0d, required 0",
                         out_valid32, out_valid64, out_tag32, c);
            end
        end
        // Asynchronous reset in the middle of a stalled stream.
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(0, 4'd7);
        @(posedge clk);
        #1 drive(4, 4'd8);
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid32, out_valid64, out_imm32, out_imm64, out_fmt32, out_fmt64,
             out_rvc32, out_tag32} !== '0) begin
            errors++;
            $display("FAIL rst_async: valid=%b imm=%h/%h fmt=%0d tag=%0d, required all 0",
                     out_valid32, out_imm32, out_imm64, out_fmt32, out_tag32);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        drive(6, 4'd9);
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_accept: in_ready=%b out_valid=%b, required 1 0",
                     in_ready32, out_valid32);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 1) begin
            errors++;
            $display("FAIL rst_scoreboard: queued=%0d, required 1", sb.size());
        end
        sb.delete();
    endtask

    // Random valid/ready pattern: order and content preserved, no drop or duplicate.
    task automatic test_random_stall();
        int   sent, got;
        logic acc;
        exp_t e;
        sent = 0;
        got = 0;
        in_valid = 1'b0;
        for (int b = 0; b < 600 && got < 30; b++) begin
            if (!in_valid && sent < 30 && $urandom_range(0, 3) != 0)
                drive(int'($urandom_range(0, NTBL - 1)), 4'(sent));
            out_ready = ($urandom_range(0, 2) != 0) || (sent >= 30);
            @(negedge clk);
            checks++;
            if (out_valid32 !== out_valid64 || in_ready32 !== in_ready64) begin
                errors++;
                $display("FAIL rand_lockstep: out_valid=%b/%b in_ready=%b/%b, required equal",
                         out_valid32, out_valid64, in_ready32, in_ready64);
            end
            if (out_valid32 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: out tag=%0d, required no output", out_tag32);
                end else begin
                    e = sb.pop_front();
                    if ({out_imm64, out_imm32, out_fmt64, out_fmt32, out_rvc32, out_tag32}
                        !== {e.imm, e.imm[31:0], e.fmt, e.fmt, e.rvc, e.tag}) begin
                        errors++;
                        $display("FAIL rand_entry: imm=%h/%h fmt=%0d rvc=%b tag=%0d, required imm=%h fmt=%0d rvc=%b tag=%0d",
                                 out_imm64, out_imm32, out_fmt32, out_rvc32, out_tag32,
                                 e.imm, e.fmt, e.rvc, e.tag);
                    end
                end
                got++;
            end
            acc = in_valid && in_ready32;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
        end
        checks++;
        if (got != 30 || sb.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d outputs, %0d left queued, required 30 and 0",
                     got, sb.size());
        end
    endtask

    initial begin
        fill_table();
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_random_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
